// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - shared constants and width helpers for the button event scheduler
package btn_pkg;

  localparam int N_BTN_DEFAULT = 5;

  // Bits needed to index n items, never below 1 so a single-button build still has an id port.
  function automatic int id_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  // Bits needed for the shared sample-rate counter that runs 0..div-1.
  function automatic int tick_width(input int div);
    return (div > 2) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/btn_filter.sv
// rtl/btn_filter.sv - per-button synchroniser and stable-sample debounce filter
module btn_filter
  import btn_pkg::*;
#(
  parameter int STABLE_CNT = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic raw,
  output logic level
);

  localparam int CW = id_width(STABLE_CNT);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic [CW-1:0] r_cnt;

  // Two-flop synchroniser for the asynchronous button pin.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= raw;
      r_sync2 <= r_sync1;
    end
  end

  // On each tick, count consecutive samples that disagree with the level; flip once enough agree.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else if (tick) begin
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(STABLE_CNT - 1)) begin
        r_level <= ~r_level;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign level = r_level;

endmodule

// File: rtl/btn_event_scheduler.sv
// rtl/btn_event_scheduler.sv - debounced button presses queued and handed out round-robin
module btn_event_scheduler
  import btn_pkg::*;
#(
  parameter int N_BTN      = N_BTN_DEFAULT,
  parameter int TICK_DIV   = 100000,
  parameter int STABLE_CNT = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_BTN-1:0]           btn_raw,
  input  logic                       ev_ready,
  input  logic                       clr_ovf,
  output logic                       ev_valid,
  output logic [id_width(N_BTN)-1:0] ev_id,
  output logic [N_BTN-1:0]           btn_level,
  output logic                       ovf
);

  localparam int IW = id_width(N_BTN);
  localparam int TW = tick_width(TICK_DIV);

  logic [TW-1:0]    r_tick_cnt;
  logic             w_tick;
  logic [N_BTN-1:0] w_level;
  logic [N_BTN-1:0] r_level_d;
  logic [N_BTN-1:0] w_rise;
  logic [N_BTN-1:0] r_pend;
  logic [N_BTN-1:0] w_clr;
  logic [N_BTN-1:0] w_drop;
  logic [IW-1:0]    w_grant;
  logic [IW-1:0]    w_idx;
  logic [IW-1:0]    r_last;
  logic [IW-1:0]    r_id;
  logic             w_found;
  logic             w_load;
  logic             r_valid;
  logic             r_ovf;

  assign w_tick = (r_tick_cnt == TW'(TICK_DIV - 1));

  // Shared sample-rate divider; one tick pulse per TICK_DIV clocks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tick_cnt <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + TW'(1);
    end
  end

  for (genvar gi = 0; gi < N_BTN; gi++) begin : g_filter
    btn_filter #(
      .STABLE_CNT(STABLE_CNT)
    ) u_filter (
      .clk  (clk),
      .rst  (rst),
      .tick (w_tick),
      .raw  (btn_raw[gi]),
      .level(w_level[gi])
    );
  end

  // Previous debounced level, so a press is a 0->1 step and a release is ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_level_d <= '0;
    end else begin
      r_level_d <= w_level;
    end
  end

  assign w_rise = w_level & ~r_level_d;

  // Round-robin pick: first pending index after the last grant, wrapping to 0.
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    w_idx   = '0;
    for (int k = 1; k <= N_BTN; k++) begin
      w_idx = IW'((int'(r_last) + k) % N_BTN);
      if (!w_found && r_pend[w_idx]) begin
        w_found = 1'b1;
        w_grant = w_idx;
      end
    end
  end

  assign w_load = (!r_valid || ev_ready) && w_found;
  assign w_clr  = w_load ? (N_BTN'(1) << w_grant) : '0;
  assign w_drop = w_rise & r_pend & ~w_clr;

  // Pending set: a press landing on the bit being granted survives, so it is not lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend <= '0;
    end else begin
      r_pend <= (r_pend & ~w_clr) | w_rise;
    end
  end

  // Output slot: refill whenever it is empty or being taken, otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_id    <= '0;
      r_last  <= IW'(N_BTN - 1);
    end else if (w_load) begin
      r_valid <= 1'b1;
      r_id    <= w_grant;
      r_last  <= w_grant;
    end else if (ev_ready) begin
      r_valid <= 1'b0;
    end
  end

  // Sticky overflow on a dropped press; a fresh drop beats a clear in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (|w_drop) begin
      r_ovf <= 1'b1;
    end else if (clr_ovf) begin
      r_ovf <= 1'b0;
    end
  end

  assign ev_valid  = r_valid;
  assign ev_id     = r_id;
  assign btn_level = w_level;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_btn_event_scheduler.sv
// tb/tb_btn_event_scheduler.sv - scoreboard bench for btn_event_scheduler
module tb_btn_event_scheduler;

  localparam int N  = 5;
  localparam int TD = 4;
  localparam int S  = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] btn_raw = '0;
  logic         ev_ready = 1'b0;
  logic         clr_ovf = 1'b0;
  logic         ev_valid;
  logic [2:0]   ev_id;
  logic [N-1:0] btn_level;
  logic         ovf;

  btn_event_scheduler #(
    .N_BTN     (N),
    .TICK_DIV  (TD),
    .STABLE_CNT(S)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_raw  (btn_raw),
    .ev_ready (ev_ready),
    .clr_ovf  (clr_ovf),
    .ev_valid (ev_valid),
    .ev_id    (ev_id),
    .btn_level(btn_level),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int exp_q[$];
  int xfer_id[$];
  int xfer_cyc[$];

  // reference model state
  bit         m_valid;
  int         m_last;
  bit [N-1:0] m_pend;
  bit [N-1:0] m_level;
  bit [N-1:0] m_rose;
  bit [N-1:0] m_prev;
  bit [N-1:0] raw_h1;
  bit [N-1:0] raw_h2;
  bit         m_ovf;
  bit         m_drop;
  int         n_edge;
  int         th[N];
  int         tn[N];
  int         g;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic int rr_pick(input bit [N-1:0] p, input int last);
    for (int k = 1; k <= N; k++) begin
      if (p[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  function automatic int seq3(input int b);
    if (xfer_id.size() < b + 3) return -1;
    return xfer_id[b] * 100 + xfer_id[b + 1] * 10 + xfer_id[b + 2];
  endfunction

  function automatic int span3(input int b);
    if (xfer_cyc.size() < b + 3) return -1;
    return xfer_cyc[b + 2] - xfer_cyc[b];
  endfunction

  function automatic int count_id(input int b, input int id);
    int c = 0;
    for (int k = b; k < xfer_id.size(); k++) if (xfer_id[k] == id) c++;
    return c;
  endfunction

  // Behavioural model: sample = raw two edges ago; a level flips when the last S tick
  // samples all disagree with it; presses become pending, granted round-robin.
  always @(posedge clk) begin
    if (rst) begin
      m_valid = 0; m_last = N - 1; m_pend = '0; m_level = '0; m_rose = '0;
      m_ovf = 0; raw_h1 = '0; raw_h2 = '0; n_edge = 0;
      for (int i = 0; i < N; i++) begin th[i] = 0; tn[i] = 0; end
      exp_q.delete();
    end else begin
      if ((!m_valid || ev_ready) && m_pend != '0) begin
        g = rr_pick(m_pend, m_last);
        m_pend[g] = 1'b0;
        m_valid = 1;
        m_last = g;
        exp_q.push_back(g);
      end else if (ev_ready) begin
        m_valid = 0;
      end
      m_drop = 0;
      for (int i = 0; i < N; i++) begin
        if (m_rose[i]) begin
          if (m_pend[i]) m_drop = 1;
          else m_pend[i] = 1'b1;
        end
      end
      if (m_drop) m_ovf = 1;
      else if (clr_ovf) m_ovf = 0;
      m_prev = m_level;
      if ((n_edge % TD) == TD - 1) begin
        for (int i = 0; i < N; i++) begin
          th[i] = ((th[i] << 1) | int'(raw_h2[i])) & ((1 << S) - 1);
          if (tn[i] < S) tn[i]++;
          if (tn[i] == S && th[i] == (m_level[i] ? 0 : (1 << S) - 1)) m_level[i] = ~m_level[i];
        end
      end
      m_rose = m_level & ~m_prev;
      raw_h2 = raw_h1;
      raw_h1 = btn_raw;
      n_edge++;
    end
  end

  // Monitor: compare every cycle, and pop the scoreboard on each transfer.
  always @(negedge clk) begin
    #1;
    cyc++;
    if (!rst) begin
      chk("ev_valid", int'(ev_valid), int'(m_valid));
      chk("btn_level", int'(btn_level), int'(m_level));
      chk("ovf", int'(ovf), int'(m_ovf));
      if (ev_valid) begin
        chk("queue_nonempty", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) chk("ev_id", int'(ev_id), exp_q[0]);
        if (ev_ready) begin
          xfer_id.push_back(int'(ev_id));
          xfer_cyc.push_back(cyc);
          if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
      end
    end
  end

  int  base;
  int  k;
  bit  flag;

  initial begin
    step(3);
    #1;
    chk("rst_valid", int'(ev_valid), 0);
    chk("rst_id", int'(ev_id), 0);
    chk("rst_level", int'(btn_level), 0);
    chk("rst_ovf", int'(ovf), 0);
    @(negedge clk);
    rst = 1'b0;
    ev_ready = 1'b1;
    step(5);

    // round-robin from reset: 0,3,4 on consecutive clocks
    base = xfer_id.size();
    btn_raw = 5'b11001;
    step(30);
    chk("rr1_seq", seq3(base), 34);
    chk("rr1_span", span3(base), 2);
    btn_raw = '0;
    step(30);
    btn_raw[3] = 1'b1;
    step(30);
    btn_raw[3] = 1'b0;
    step(30);
    base = xfer_id.size();
    btn_raw = 5'b11001;
    step(30);
    chk("rr2_seq", seq3(base), 403);
    chk("rr2_span", span3(base), 2);
    btn_raw = '0;
    step(30);

    // single press latency
    btn_raw[2] = 1'b1;
    k = 0;
    while (!btn_level[2] && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("press_lvl_latency_ok", int'(k <= 14), 1);
    step(2);
    chk("press_valid", int'(ev_valid), 1);
    chk("press_id", int'(ev_id), 2);
    @(negedge clk);
    chk("press_done", int'(ev_valid), 0);
    btn_raw[2] = 1'b0;
    step(30);

    // bounce reject
    base = xfer_id.size();
    flag = 0;
    for (int t = 0; t < 8; t++) begin
      btn_raw[1] = ~btn_raw[1];
      repeat (5) begin
        @(negedge clk);
        if (btn_level[1]) flag = 1;
      end
    end
    step(20);
    chk("bounce_level", int'(flag), 0);
    chk("bounce_events", xfer_id.size() - base, 0);

    // backpressure, overflow and clear
    ev_ready = 1'b0;
    btn_raw[2] = 1'b1;
    step(25);
    flag = 1;
    repeat (20) begin
      @(negedge clk);
      if (!(ev_valid && ev_id == 3'd2)) flag = 0;
    end
    chk("bp_hold", int'(flag), 1);
    btn_raw[2] = 1'b0; step(30);
    btn_raw[2] = 1'b1; step(30);
    chk("bp_pend_no_ovf", int'(ovf), 0);
    btn_raw[2] = 1'b0; step(30);
    btn_raw[2] = 1'b1; step(30);
    chk("bp_ovf_set", int'(ovf), 1);
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    chk("bp_ovf_clr", int'(ovf), 0);
    base = xfer_id.size();
    ev_ready = 1'b1;
    step(5);
    chk("bp_drain", xfer_id.size() - base, 2);
    btn_raw[2] = 1'b0;
    step(30);

    // set wins: third press rises on the clock that grants pending[1]
    ev_ready = 1'b0;
    btn_raw[1] = 1'b1; step(30);
    btn_raw[1] = 1'b0; step(30);
    btn_raw[1] = 1'b1; step(30);
    btn_raw[1] = 1'b0; step(30);
    base = xfer_id.size();
    btn_raw[1] = 1'b1;
    flag = 0;
    for (int t = 0; t < 40 && !flag; t++) begin
      @(negedge clk);
      if (btn_level[1]) begin
        ev_ready = 1'b1;
        flag = 1;
      end
    end
    chk("sw_rise_seen", int'(flag), 1);
    step(10);
    chk("sw_count", count_id(base, 1), 3);
    chk("sw_no_ovf", int'(ovf), 0);
    btn_raw[1] = 1'b0;
    step(30);

    // asynchronous reset with an event presented and two pending
    ev_ready = 1'b0;
    btn_raw = 5'b11001;
    step(30);
    chk("ar_valid_before", int'(ev_valid), 1);
    rst = 1'b1;
    #1;
    chk("ar_valid", int'(ev_valid), 0);
    chk("ar_level", int'(btn_level), 0);
    btn_raw = '0;
    step(3);
    rst = 1'b0;
    ev_ready = 1'b1;
    base = xfer_id.size();
    step(60);
    chk("ar_no_stale", xfer_id.size() - base, 0);

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int b = 0; b < N; b++) if ($urandom_range(0, 24) == 0) btn_raw[b] = ~btn_raw[b];
      ev_ready = ($urandom_range(0, 3) != 0);
      clr_ovf = ($urandom_range(0, 19) == 0);
    end
    btn_raw = '0;
    ev_ready = 1'b1;
    clr_ovf = 1'b0;
    step(60);
    chk("final_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/btn_event_scheduler.md
# btn_event_scheduler

Front-end controller between the board push-buttons and the signed-multiplier top-level FSM. Synchronises and debounces N raw button inputs from one shared sample-rate divider. Turns each accepted press into a pending event. Hands events one at a time to the consumer over a valid/ready handshake, using round-robin arbitration so simultaneous presses are neither lost nor reordered unfairly.

## Interface
- N_BTN, 5: number of buttons, range 1..16
- TICK_DIV, 100000: clk cycles per sample tick, ≥2
- STABLE_CNT, 3: consecutive differing samples required to flip a debounced level, ≥1
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high; clock clk
- btn_raw  in  N_BTN  raw asynchronous button inputs, active-high
- ev_ready  in  1  consumer accepts event this cycle
- clr_ovf  in  1  synchronous clear of ovf
- ev_valid  out  1  event available
- ev_id  out  clog2(N_BTN) (min 1)  index of pressed button
- btn_level  out  N_BTN  debounced levels
- ovf  out  1  sticky: a press was dropped

## Operation
- Sync: each btn_raw bit passes through a 2-flop synchroniser every clk.
- Tick: a shared counter runs 0..TICK_DIV-1; tick=1 for one clk when the count equals TICK_DIV-1, then the counter wraps to 0.
- Filter, per button, on tick only:
  - synced sample == btn_level → cnt=0
  - else if cnt==STABLE_CNT-1 → btn_level flips, cnt=0
  - else cnt++
- Press detect: a 0→1 transition of btn_level sets pending[i] on the next clk. Release (1→0) generates no event.
- Arbiter: round-robin over pending. Search starts at last_grant+1 and wraps N_BTN-1→0. last_grant resets to N_BTN-1, so index 0 has first priority.
- Output register loads when (!ev_valid || ev_ready) and any pending bit is set:
  - ev_id ← grant
  - ev_valid ← 1
  - pending[grant] cleared
  - last_grant ← grant
- If there is no pending bit and ev_ready=1, ev_valid←0.
- While ev_valid=1 and ev_ready=0, ev_id holds stable.
- Set and clear of the same pending bit in one clk: set wins, so the new press stays pending.
- New press on a bit already pending and not being cleared that cycle: ovf←1; that press is dropped.
- clr_ovf=1 clears ovf; a simultaneous new overflow takes priority and ovf stays 1.

## Timing
- Reset values: ev_valid=0, ev_id=0, btn_level=0, ovf=0. All internal state is 0, except last_grant=N_BTN-1.
- Reset mid-operation discards pending events and any in-flight event immediately.
- btn_raw change to btn_level change: 2 clk sync plus STABLE_CNT ticks. Worst case is 2 + STABLE_CNT·TICK_DIV clk.
- btn_level rise to ev_valid: 2 clk (pending set, then output load), provided the output slot is free.
- Throughput: one event per clk with ev_ready held high.
- Handshake: a transfer occurs on any clk where ev_valid && ev_ready. ev_valid never drops without a transfer.

## Structure
- Package btn_pkg holds:
  - the N_BTN default
  - an id-width constant/function: clog2 with minimum 1
  - the shared tick-counter width derived from TICK_DIV
- Sub-module btn_filter holds the synchroniser and stable counter for one button. It has inputs clk, rst, tick, raw and output level, and is instantiated N_BTN times in a generate loop.
- Divider, edge detect, pending register, arbiter and output register live in btn_event_scheduler.

## Test plan
Bench parameters: N_BTN=5, TICK_DIV=4, STABLE_CNT=3.
- Single press: btn_raw[2] held 1 → btn_level[2] rises within 2+12 clk. Two clk later, ev_valid=1 with ev_id=2. With ev_ready=1 it transfers, then ev_valid=0.
- Bounce reject: btn_raw[1] toggles every 5 clk for 40 clk → btn_level[1] stays 0 and no event is produced.
- Round-robin: buttons 0, 3, 4 rise on the same clk with ev_ready=1 → ev_id sequence 0, 3, 4 on consecutive clk. Repeat with last_grant=3 → order 4, 0, 3.
- Backpressure: ev_ready=0 while a press on 2 is presented → ev_valid and ev_id=2 stay stable for 20 clk. A second press on 2 while pending is already set → ovf=1. clr_ovf → ovf=0.
- Set-wins: a press on 1 coincides with the load of pending[1] → ev_id=1 is presented, and a second ev_id=1 follows after the transfer.
- Async reset mid-operation: assert rst with ev_valid=1 and two pending events → within the same cycle, ev_valid=0 and btn_level=0. After release, no stale events appear.
